// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_rx.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__invz_rx.sv - invz bus receiver: sync, deglitch, edge strobes (optional bus-hold via GF180MCU_FD_SC_MCU9T5V0__INVZ_RX_HOLD_EN)
module gf180mcu_fd_sc_mcu9t5v0__invz_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic CLK,
    input  logic RN,
    input  logic ZN,
    input  logic EN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic VALID
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_TRACK,
        ST_HOLD
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] zn_sync;
    logic                   zn_s;
    logic                   d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   q_q;
    logic                   q_n;
    logic                   q_prev;
    logic                   rise_q;
    logic                   fall_q;
    logic                   track_en;

    // Data synchronizer; resets to an undriven-high line so d starts at 0.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            zn_sync <= '1;
        end else begin
            zn_sync <= {zn_sync[SYNC_STAGES-2:0], ZN};
        end
    end

    assign zn_s = zn_sync[SYNC_STAGES-1];
    assign d    = ~zn_s;

`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_RX_HOLD_EN
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   en_s;

    // Enable synchronizer, same depth as data so both stay aligned.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            en_sync <= '0;
        end else begin
            en_sync <= {en_sync[SYNC_STAGES-2:0], EN};
        end
    end

    assign en_s = en_sync[SYNC_STAGES-1];
    // Filtering needs both a settled TRACK state and a live enable, so a
    // dropping enable beats a terminal count on the same edge.
    assign track_en = (state_q == ST_TRACK) && en_s;
`else
    logic unused_en;

    assign unused_en = EN;
    assign track_en  = (state_q == ST_TRACK);
`endif

    // Next state and filter counter / recovered data decision.
    always_comb begin
        state_d = ST_TRACK;
        cnt_d   = cnt_q;
        q_n     = q_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0__INVZ_RX_HOLD_EN
        state_d = en_s ? ST_TRACK : ST_HOLD;
`endif
        if (track_en) begin
            if (d == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                q_n   = d;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State, filter and output registers; strobes come from comparing Q
    // against its previous value, so they trail the Q change by one edge.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            q_prev  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_n;
            q_prev  <= q_q;
            rise_q  <= q_q & ~q_prev;
            fall_q  <= ~q_q & q_prev;
        end
    end

    assign Q     = q_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign VALID = (state_q == ST_TRACK);

endmodule
